pc_sequencer: RTL

- Registered program-counter unit: holds the architectural PC and computes the next fetch address each cycle.
- Supports sequential step, conditional relative branch (taken on zero or on non-zero), call/return through an internal return-address stack (RAS), stall and halt.
- Parametrised successor of the combinational next-PC logic; sits between instruction fetch and the decode/ALU zero flag.

---
 rtl/pc_sequencer_pkg.sv | 31 +++
 rtl/pc_sequencer_ras.sv | 67 ++++++
 rtl/pc_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_STEP,
        ACT_BRANCH,
        ACT_CALL,
        ACT_RET
    } action_e;

    localparam int SEXT_MAX_W = 64;
    localparam int SEXT_IDX_W = $clog2(SEXT_MAX_W);

    // Sign-extends the low 'width' bits of val to the full SEXT_MAX_W bits.
    function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] val,
                                                   input int unsigned           width);
        logic [SEXT_MAX_W-1:0] hi_mask;
        logic [SEXT_IDX_W-1:0] sign_idx;
        hi_mask  = {SEXT_MAX_W{1'b1}} << width;
        sign_idx = SEXT_IDX_W'(width - 1);
        return val[sign_idx] ? (val | hi_mask) : (val & ~hi_mask);
    endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a push when full silently overwrites the oldest entry.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_CNT);
    // sp_q is the next free slot, so the newest entry sits just below it.
    assign top_o   = mem_q[sp_q - 1'b1];

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        if (clear_i) begin
            sp_d    = '0;
            count_d = '0;
        end else if (push_i) begin
            sp_d = sp_q + 1'b1;
            if (!full_o) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop_i && !empty_o) begin
            sp_d    = sp_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_i && !clear_i && (sp_q == PTR_W'(gi))) begin
                    mem_q[gi] <= data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with relative branch, call/return via RAS, stall and halt.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  INSTR_WIDTH  = 9,
    parameter int                  OFFSET_WIDTH = 7,
    parameter int                  PC_STEP      = 1,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   halt,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   branch,
    input  logic                   branch_ne,
    input  logic                   zero,
    input  logic                   call,
    input  logic                   ret,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    next_pc,
    output logic                   running,
    output logic                   branch_taken,
    output logic                   ras_overflow,
    output logic                   ras_underflow
);
    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    state_e                state_q, state_d;
    action_e               action;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  load_reset;
    logic                  ras_push, ras_pop, ras_clear;
    logic                  ras_empty, ras_full;
    logic [PC_WIDTH-1:0]   ras_top;
    logic [PC_WIDTH-1:0]   pc_seq;
    logic [PC_WIDTH-1:0]   offset_ext;
    logic [SEXT_MAX_W-1:0] offset_raw;

    assign offset_raw = SEXT_MAX_W'(instruction[OFFSET_WIDTH-1:0]);
    assign offset_ext = PC_WIDTH'(sext(offset_raw, OFFSET_WIDTH));
    assign pc_seq     = pc_q + STEP;

    generate
        if (INSTR_WIDTH > OFFSET_WIDTH) begin : g_opcode_bits
            logic unused_opcode;
            assign unused_opcode = ^instruction[INSTR_WIDTH-1:OFFSET_WIDTH];
        end
    endgenerate

    ras_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .clear_i (ras_clear),
        .data_i  (pc_seq),
        .top_o   (ras_top),
        .empty_o (ras_empty),
        .full_o  (ras_full)
    );

    always_comb begin
        state_d    = state_q;
        action     = ACT_HOLD;
        load_reset = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ras_clear  = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d    = RUN;
                    load_reset = 1'b1;
                    ras_clear  = 1'b1;
                    ovf_d      = 1'b0;
                    unf_d      = 1'b0;
                end
            end
            RUN: begin
                // Strict priority: exactly one action wins each cycle.
                if (stall) begin
                    action = ACT_HOLD;
                end else if (halt) begin
                    state_d = HALTED;
                end else if (ret) begin
                    action = ACT_RET;
                    if (ras_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        ras_pop = 1'b1;
                    end
                end else if (call) begin
                    action   = ACT_CALL;
                    ras_push = 1'b1;
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end
                end else if (branch && (zero ^ branch_ne)) begin
                    action = ACT_BRANCH;
                end else begin
                    action = ACT_STEP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (load_reset) begin
            pc_d = RESET_PC;
        end else begin
            case (action)
                ACT_STEP:             pc_d = pc_seq;
                ACT_BRANCH, ACT_CALL: pc_d = pc_q + offset_ext;
                ACT_RET:              pc_d = ras_empty ? pc_seq : ras_top;
                default:              pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign pc            = pc_q;
    assign next_pc       = pc_d;
    assign running       = (state_q == RUN);
    assign branch_taken  = (action == ACT_BRANCH);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule
